adxl362_sample_sequencer: RTL

//  Transaction scheduler sitting between spi_controller-level logic and the spi engine.

---
 rtl/adxl362_sample_sequencer_pkg.sv | 28 ++
 rtl/adxl362_sample_sequencer_sync_edge_detect.sv | 28 ++
 rtl/adxl362_sample_sequencer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/adxl362_sample_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// adxl362_sample_sequencer_pkg: ADXL362 command/register codes, states. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package adxl362_sample_sequencer_pkg;

  localparam logic [7:0] CMD_WRITE     = 8'h0A;
  localparam logic [7:0] CMD_READ      = 8'h0B;
  localparam logic [7:0] REG_POWER_CTL = 8'h2D;
  localparam logic [7:0] REG_XDATA_L   = 8'h0E;

  localparam logic [2:0] ST_CFG_ISSUE = 3'd0;
  localparam logic [2:0] ST_CFG_WAIT  = 3'd1;
  localparam logic [2:0] ST_WAIT_TRIG = 3'd2;
  localparam logic [2:0] ST_RD_ISSUE  = 3'd3;
  localparam logic [2:0] ST_RD_WAIT   = 3'd4;
  localparam logic [2:0] ST_PUBLISH   = 3'd5;

  localparam logic [2:0] LAST_IDX = 3'd5;

  function automatic logic [7:0] rd_addr(input logic [2:0] idx);
    return REG_XDATA_L + {5'd0, idx};
  endfunction

endpackage

`default_nettype wire

// File: rtl/adxl362_sample_sequencer_sync_edge_detect.sv
// ---------------------------------------------------------------------------
// adxl362_sample_sequencer_sync_edge_detect: 2-flop sync + rising-edge pulse. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module adxl362_sample_sequencer_sync_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise
);

  // [1:0] is the synchroniser, [2] holds the previous synchronised level
  logic [2:0] sync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= 3'b000;
    end else begin
      sync_q <= {sync_q[1:0], async_in};
    end
  end

  assign rise = sync_q[1] & ~sync_q[2];

endmodule

`default_nettype wire

// File: rtl/adxl362_sample_sequencer.sv
// ---------------------------------------------------------------------------
// adxl362_sample_sequencer: POWER_CTL setup, then triggered XYZ six-byte bursts. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module adxl362_sample_sequencer
  import adxl362_sample_sequencer_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV  = 100000,
  parameter int unsigned TIMEOUT     = 4096,
  parameter logic [7:0]  PWR_CTL_VAL = 8'h02
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        int1_i,
  input  logic [7:0]  rx_data,
  input  logic        spi_active,
  output logic        start,
  output logic [7:0]  command,
  output logic [7:0]  address,
  output logic [7:0]  tx_data,
  output logic [15:0] x_data,
  output logic [15:0] y_data,
  output logic [15:0] z_data,
  output logic        sample_valid,
  output logic        overrun,
  output logic        timeout_err,
  output logic        busy
);

  localparam int unsigned     TO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  logic [2:0]      state, state_nxt;
  logic [2:0]      idx;
  logic            pending, seen_active, cfg_done;
  logic [TO_W-1:0] to_cnt;
  logic [7:0]      shadow [0:4];
  logic            int1_rise, tick, trig, consume;
  logic            in_issue, in_wait, issue, done, abort;

  adxl362_sample_sequencer_sync_edge_detect u_int1_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (int1_i),
    .rise     (int1_rise)
  );

  generate
    if (SAMPLE_DIV == 0) begin : g_no_timer
      assign tick = 1'b0;
    end else begin : g_timer
      localparam int unsigned     TMR_W    = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
      localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SAMPLE_DIV - 1);
      logic [TMR_W-1:0] tmr;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          tmr <= '0;
        end else if (cfg_done) begin
          tmr <= (tmr == TMR_LAST) ? '0 : tmr + TMR_W'(1);
        end
      end

      assign tick = cfg_done && (tmr == TMR_LAST);
    end
  endgenerate

  assign trig     = tick | int1_rise;
  assign consume  = (state == ST_WAIT_TRIG) && pending && enable;
  assign in_issue = (state == ST_CFG_ISSUE) || (state == ST_RD_ISSUE);
  assign in_wait  = (state == ST_CFG_WAIT) || (state == ST_RD_WAIT);
  assign issue    = in_issue && !spi_active;
  assign done     = in_wait && seen_active && !spi_active;
  assign abort    = in_wait && !done && (to_cnt == TO_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_CFG_ISSUE: if (!spi_active) state_nxt = ST_CFG_WAIT;
      ST_CFG_WAIT:  if (done) state_nxt = ST_WAIT_TRIG;
                    else if (abort) state_nxt = ST_CFG_ISSUE;
      ST_WAIT_TRIG: if (consume) state_nxt = ST_RD_ISSUE;
      ST_RD_ISSUE:  if (!spi_active) state_nxt = ST_RD_WAIT;
      ST_RD_WAIT:   if (done) state_nxt = (idx == LAST_IDX) ? ST_PUBLISH : ST_RD_ISSUE;
                    else if (abort) state_nxt = ST_CFG_ISSUE;
      ST_PUBLISH:   state_nxt = ST_WAIT_TRIG;
      default:      state_nxt = ST_CFG_ISSUE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_CFG_ISSUE;
      idx          <= '0;
      pending      <= 1'b0;
      seen_active  <= 1'b0;
      cfg_done     <= 1'b0;
      to_cnt       <= '0;
      start        <= 1'b0;
      command      <= '0;
      address      <= '0;
      tx_data      <= '0;
      x_data       <= '0;
      y_data       <= '0;
      z_data       <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
      timeout_err  <= 1'b0;
      busy         <= 1'b0;
      for (int i = 0; i < 5; i++) shadow[i] <= '0;
    end else begin
      state        <= state_nxt;
      busy         <= (state_nxt != ST_WAIT_TRIG);
      start        <= issue;
      sample_valid <= 1'b0;
      timeout_err  <= abort;
      // A trigger coinciding with consumption re-arms pending without an overrun
      overrun      <= trig && pending && !consume;

      if (trig) pending <= 1'b1;
      else if (consume) pending <= 1'b0;

      if (consume) idx <= '0;

      if (issue) begin
        seen_active <= 1'b0;
        to_cnt      <= '0;
        if (state == ST_CFG_ISSUE) begin
          command <= CMD_WRITE;
          address <= REG_POWER_CTL;
          tx_data <= PWR_CTL_VAL;
        end else begin
          command <= CMD_READ;
          address <= rd_addr(idx);
          tx_data <= 8'h00;
        end
      end else if (in_wait) begin
        if (spi_active) seen_active <= 1'b1;
        to_cnt <= to_cnt + TO_W'(1);
      end

      if (done && (state == ST_CFG_WAIT)) cfg_done <= 1'b1;

      // The sixth byte goes straight to z so the publish lands one cycle after it
      if (done && (state == ST_RD_WAIT)) begin
        if (idx == LAST_IDX) begin
          x_data       <= {shadow[1], shadow[0]};
          y_data       <= {shadow[3], shadow[2]};
          z_data       <= {rx_data, shadow[4]};
          sample_valid <= 1'b1;
        end else begin
          shadow[idx] <= rx_data;
          idx         <= idx + 3'd1;
        end
      end
    end
  end

endmodule

`default_nettype wire
